// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD frame read sequencer.
// Holds the sequencer state encoding and the line-length word alignment mask.
package lcd_seq_pkg;

    localparam int unsigned LCD_ADDRESSWIDTH    = 32;
    localparam int unsigned LCD_BYTEENABLEWIDTH = 4;
    localparam int unsigned LCD_LINESWIDTH      = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GO   = 2'd1,
        ARM  = 2'd2,
        WAIT = 2'd3
    } seq_state_e;

    // Clears the byte-offset bits so a length covers whole master words only.
    function automatic logic [63:0] word_align_mask(input int unsigned bytes_per_word);
        return ~(64'(bytes_per_word) - 64'd1);
    endfunction

    localparam logic [63:0] LCD_WORD_ALIGN_MASK = word_align_mask(LCD_BYTEENABLEWIDTH);

endpackage

// File: rtl/lcd_frame_cfg_shadow.sv
// Frame configuration banks: a commit-loaded shadow set and an active set
// copied from the shadow when the sequencer accepts a frame.
module lcd_frame_cfg_shadow
    import lcd_seq_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH    = LCD_ADDRESSWIDTH,
    parameter int unsigned LINESWIDTH      = LCD_LINESWIDTH,
    parameter logic [63:0] LINE_ALIGN_MASK = LCD_WORD_ALIGN_MASK
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_commit,
    input  logic [ADDRESSWIDTH-1:0] cfg_frame_base,
    input  logic [ADDRESSWIDTH-1:0] cfg_line_bytes,
    input  logic [ADDRESSWIDTH-1:0] cfg_line_stride,
    input  logic [LINESWIDTH-1:0]   cfg_lines,
    input  logic                    accept,
    output logic [ADDRESSWIDTH-1:0] shadow_base,
    output logic [ADDRESSWIDTH-1:0] shadow_line_bytes,
    output logic [LINESWIDTH-1:0]   shadow_lines,
    output logic [ADDRESSWIDTH-1:0] act_line_bytes,
    output logic [ADDRESSWIDTH-1:0] act_line_stride,
    output logic [LINESWIDTH-1:0]   act_lines
);

    localparam logic [ADDRESSWIDTH-1:0] ALIGN_MASK = ADDRESSWIDTH'(LINE_ALIGN_MASK);

    logic [ADDRESSWIDTH-1:0] shadow_stride;

    // Shadow set, written by software commits at any time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_base       <= '0;
            shadow_line_bytes <= '0;
            shadow_stride     <= '0;
            shadow_lines      <= '0;
        end else if (cfg_commit) begin
            shadow_base       <= cfg_frame_base;
            shadow_line_bytes <= cfg_line_bytes & ALIGN_MASK;
            shadow_stride     <= cfg_line_stride;
            shadow_lines      <= cfg_lines;
        end
    end

    // Active set, frozen for the duration of a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_line_bytes  <= '0;
            act_line_stride <= '0;
            act_lines       <= '0;
        end else if (accept) begin
            act_line_bytes  <= shadow_line_bytes;
            act_line_stride <= shadow_stride;
            act_lines       <= shadow_lines;
        end
    end

endmodule

// File: rtl/lcd_frame_read_sequencer.sv
// Per-frame sequencer for the LCD scanout burst read master: issues one
// go/base/length command per line and waits for each line to drain.
module lcd_frame_read_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned ADDRESSWIDTH    = LCD_ADDRESSWIDTH,
    parameter int unsigned BYTEENABLEWIDTH = LCD_BYTEENABLEWIDTH,
    parameter int unsigned LINESWIDTH      = LCD_LINESWIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cfg_enable,
    input  logic [ADDRESSWIDTH-1:0] cfg_frame_base,
    input  logic [ADDRESSWIDTH-1:0] cfg_line_bytes,
    input  logic [ADDRESSWIDTH-1:0] cfg_line_stride,
    input  logic [LINESWIDTH-1:0]   cfg_lines,
    input  logic                    cfg_commit,
    input  logic                    frame_start,
    input  logic                    underrun_clr,
    output logic                    rm_go,
    output logic [ADDRESSWIDTH-1:0] rm_base,
    output logic [ADDRESSWIDTH-1:0] rm_length,
    output logic                    rm_fixed_location,
    input  logic                    rm_done,
    output logic                    busy,
    output logic [LINESWIDTH-1:0]   line_index,
    output logic                    frame_done,
    output logic                    underrun
);

    seq_state_e state_q, state_d;

    logic                    rm_go_d;
    logic [ADDRESSWIDTH-1:0] rm_base_d;
    logic [ADDRESSWIDTH-1:0] rm_length_d;
    logic [LINESWIDTH-1:0]   line_index_d;
    logic                    frame_done_d;
    logic                    underrun_d;
    logic                    busy_d;
    logic                    abort_q, abort_d;
    logic                    accept_c;
    logic                    last_line;

    logic [ADDRESSWIDTH-1:0] shadow_base;
    logic [ADDRESSWIDTH-1:0] shadow_line_bytes;
    logic [LINESWIDTH-1:0]   shadow_lines;
    logic [ADDRESSWIDTH-1:0] act_line_bytes;
    logic [ADDRESSWIDTH-1:0] act_line_stride;
    logic [LINESWIDTH-1:0]   act_lines;

    lcd_frame_cfg_shadow #(
        .ADDRESSWIDTH    (ADDRESSWIDTH),
        .LINESWIDTH      (LINESWIDTH),
        .LINE_ALIGN_MASK (word_align_mask(BYTEENABLEWIDTH))
    ) u_cfg_shadow (
        .clk               (clk),
        .reset_n           (reset_n),
        .cfg_commit        (cfg_commit),
        .cfg_frame_base    (cfg_frame_base),
        .cfg_line_bytes    (cfg_line_bytes),
        .cfg_line_stride   (cfg_line_stride),
        .cfg_lines         (cfg_lines),
        .accept            (accept_c),
        .shadow_base       (shadow_base),
        .shadow_line_bytes (shadow_line_bytes),
        .shadow_lines      (shadow_lines),
        .act_line_bytes    (act_line_bytes),
        .act_line_stride   (act_line_stride),
        .act_lines         (act_lines)
    );

    assign last_line         = (line_index == act_lines - LINESWIDTH'(1));
    assign rm_fixed_location = 1'b0;

    // Next-state and next-output logic; rm_base doubles as the line address.
    always_comb begin
        state_d      = state_q;
        rm_go_d      = 1'b0;
        rm_base_d    = rm_base;
        rm_length_d  = rm_length;
        line_index_d = line_index;
        frame_done_d = 1'b0;
        underrun_d   = underrun;
        accept_c     = 1'b0;
        abort_d      = (state_q == IDLE) ? 1'b0 : (abort_q | frame_start);

        // A set in the same cycle as a clear wins.
        if (state_q != IDLE && frame_start) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_start && cfg_enable) begin
                    if (shadow_lines == '0 || shadow_line_bytes == '0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        accept_c     = 1'b1;
                        state_d      = GO;
                        rm_go_d      = 1'b1;
                        rm_base_d    = shadow_base;
                        rm_length_d  = shadow_line_bytes;
                        line_index_d = '0;
                    end
                end
            end
            GO: begin
                state_d = ARM;
            end
            // The master's done is still stale from its idle period here.
            ARM: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (rm_done) begin
                    if (last_line || !cfg_enable || abort_d) begin
                        state_d      = IDLE;
                        frame_done_d = last_line;
                    end else begin
                        state_d      = GO;
                        rm_go_d      = 1'b1;
                        rm_base_d    = rm_base + act_line_stride;
                        rm_length_d  = act_line_bytes;
                        line_index_d = line_index + LINESWIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rm_go      <= 1'b0;
            rm_base    <= '0;
            rm_length  <= '0;
            line_index <= '0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            busy       <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rm_go      <= rm_go_d;
            rm_base    <= rm_base_d;
            rm_length  <= rm_length_d;
            line_index <= line_index_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
            busy       <= busy_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: tb/tb_lcd_frame_read_sequencer.sv
// Bench for lcd_frame_read_sequencer: directed scenarios plus random traffic,
// checked every cycle against a frame/line-level reference model.
module tb_lcd_frame_read_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned LW = 12;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_enable;
    logic [AW-1:0] cfg_frame_base;
    logic [AW-1:0] cfg_line_bytes;
    logic [AW-1:0] cfg_line_stride;
    logic [LW-1:0] cfg_lines;
    logic          cfg_commit;
    logic          frame_start;
    logic          underrun_clr;
    logic          rm_go;
    logic [AW-1:0] rm_base;
    logic [AW-1:0] rm_length;
    logic          rm_fixed_location;
    logic          rm_done;
    logic          busy;
    logic [LW-1:0] line_index;
    logic          frame_done;
    logic          underrun;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int lat    = 20;

    // Event logs.
    logic [AW-1:0] go_base_q[$];
    logic [AW-1:0] go_len_q[$];
    int            go_cyc_q[$];
    int            fdone_cnt = 0;

    // Reference model state.
    logic [AW-1:0] m_sh_base, m_sh_bytes, m_sh_stride;
    int            m_sh_lines;
    bit            m_act;
    logic [AW-1:0] m_bytes, m_stride, m_addr, m_len;
    int            m_lines, m_line, m_ph;
    bit            m_abort, m_go, m_fdone, m_under;

    lcd_frame_read_sequencer #(
        .ADDRESSWIDTH    (AW),
        .BYTEENABLEWIDTH (BW),
        .LINESWIDTH      (LW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cfg_enable        (cfg_enable),
        .cfg_frame_base    (cfg_frame_base),
        .cfg_line_bytes    (cfg_line_bytes),
        .cfg_line_stride   (cfg_line_stride),
        .cfg_lines         (cfg_lines),
        .cfg_commit        (cfg_commit),
        .frame_start       (frame_start),
        .underrun_clr      (underrun_clr),
        .rm_go             (rm_go),
        .rm_base           (rm_base),
        .rm_length         (rm_length),
        .rm_fixed_location (rm_fixed_location),
        .rm_done           (rm_done),
        .busy              (busy),
        .line_index        (line_index),
        .frame_done        (frame_done),
        .underrun          (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_sh_base = '0; m_sh_bytes = '0; m_sh_stride = '0; m_sh_lines = 0;
        m_act = 0; m_bytes = '0; m_stride = '0; m_addr = '0; m_len = '0;
        m_lines = 0; m_line = 0; m_ph = 0;
        m_abort = 0; m_go = 0; m_fdone = 0; m_under = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit nxt_go;
        bit nxt_fd;
        nxt_go = 0;
        nxt_fd = 0;
        if (m_act && frame_start) m_under = 1;
        else if (underrun_clr)    m_under = 0;
        if (!m_act) begin
            if (frame_start && cfg_enable) begin
                if (m_sh_lines == 0 || m_sh_bytes == 0) begin
                    nxt_fd = 1;
                end else begin
                    m_act = 1; m_abort = 0;
                    m_bytes = m_sh_bytes; m_stride = m_sh_stride; m_lines = m_sh_lines;
                    m_len = m_sh_bytes; m_addr = m_sh_base; m_line = 0; m_ph = 0;
                    nxt_go = 1;
                end
            end
        end else begin
            if (frame_start) m_abort = 1;
            if (m_ph < 2) begin
                m_ph++;
            end else if (rm_done) begin
                if (m_line == m_lines - 1 || !cfg_enable || m_abort) begin
                    m_act = 0;
                    nxt_fd = (m_line == m_lines - 1);
                end else begin
                    m_line++; m_addr = m_addr + m_stride; m_len = m_bytes; m_ph = 0;
                    nxt_go = 1;
                end
            end
        end
        if (cfg_commit) begin
            m_sh_base   = cfg_frame_base;
            m_sh_bytes  = cfg_line_bytes - (cfg_line_bytes % BW);
            m_sh_stride = cfg_line_stride;
            m_sh_lines  = int'(cfg_lines);
        end
        m_go = nxt_go;
        m_fdone = nxt_fd;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            cyc_n++;
            if (!reset_n) model_reset();
            chk("rm_go", rm_go, m_go);
            chk("rm_base", rm_base, m_addr);
            chk("rm_length", rm_length, m_len);
            chk("busy", busy, m_act);
            chk("line_index", line_index, m_line);
            chk("frame_done", frame_done, m_fdone);
            chk("underrun", underrun, m_under);
            chk("rm_fixed_location", rm_fixed_location, 0);
            if (rm_go) begin
                go_base_q.push_back(rm_base);
                go_len_q.push_back(rm_length);
                go_cyc_q.push_back(cyc_n);
            end
            if (frame_done) fdone_cnt++;
            if (reset_n) model_step();
        end
    end

    // Read master stand-in: done drops after go and returns lat cycles later.
    initial begin
        int cnt;
        bit go_s;
        cnt = 0;
        rm_done = 1'b1;
        forever begin
            @(negedge clk);
            go_s = rm_go;
            @(posedge clk);
            #1;
            if (!reset_n) begin
                cnt = 0; rm_done = 1'b1;
            end else if (go_s && lat > 0) begin
                rm_done = 1'b0; cnt = lat;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) rm_done = 1'b1;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            frame_start = 0; cfg_commit = 0; underrun_clr = 0;
        end
    endtask

    task automatic commit(input logic [AW-1:0] b, input logic [AW-1:0] n,
                          input logic [AW-1:0] s, input int l);
        cfg_frame_base = b; cfg_line_bytes = n; cfg_line_stride = s; cfg_lines = LW'(l);
        cfg_commit = 1;
        cyc(1);
    endtask

    task automatic start();
        frame_start = 1;
        cyc(1);
    endtask

    task automatic clear_logs();
        go_base_q.delete(); go_len_q.delete(); go_cyc_q.delete(); fdone_cnt = 0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 2000) begin cyc(1); k++; end
        chk(nm, busy, 0);
        cyc(2);
    endtask

    task automatic wait_line(input int idx, input string nm);
        int k;
        k = 0;
        while (line_index != LW'(idx) && k < 500) begin cyc(1); k++; end
        chk(nm, line_index, idx);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] exp_base[3];
        reset_n = 0; cfg_enable = 1; cfg_frame_base = '0; cfg_line_bytes = '0;
        cfg_line_stride = '0; cfg_lines = '0; cfg_commit = 0; frame_start = 0; underrun_clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rm_go", rm_go, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rm_base", rm_base, 0);
        reset_n = 1;
        cyc(2);

        // Basic three-line frame.
        lat = 20;
        commit(32'h1000, 32'h640, 32'h800, 3);
        clear_logs();
        start();
        chk("first_go_latency", rm_go, 1);
        wait_idle("basic_timeout");
        exp_base[0] = 32'h1000; exp_base[1] = 32'h1800; exp_base[2] = 32'h2000;
        chk("basic_go_count", go_base_q.size(), 3);
        for (int i = 0; i < 3 && i < go_base_q.size(); i++) begin
            chk("basic_base", go_base_q[i], exp_base[i]);
            chk("basic_len", go_len_q[i], 32'h640);
        end
        chk("basic_frame_done_count", fdone_cnt, 1);

        // Alignment, then empty frame.
        commit(32'h2000, 32'h643, 32'h100, 1);
        clear_logs();
        start();
        wait_idle("align_timeout");
        chk("align_go_count", go_len_q.size(), 1);
        if (go_len_q.size() > 0) chk("align_len", go_len_q[0], 32'h640);
        commit(32'h2000, 32'h640, 32'h100, 0);
        clear_logs();
        start();
        chk("empty_frame_done", frame_done, 1);
        cyc(3);
        chk("empty_go_count", go_base_q.size(), 0);
        chk("empty_frame_done_count", fdone_cnt, 1);

        // Double buffering.
        commit(32'h1000, 32'h40, 32'h100, 3);
        clear_logs();
        start();
        wait_line(1, "dbuf_line1_timeout");
        commit(32'h9000, 32'h40, 32'h100, 3);
        wait_idle("dbuf_timeout");
        chk("dbuf_go_count", go_base_q.size(), 3);
        if (go_base_q.size() == 3) chk("dbuf_last_base", go_base_q[2], 32'h1200);
        start();
        chk("dbuf_next_base", rm_base, 32'h9000);
        wait_idle("dbuf2_timeout");

        // Underrun.
        commit(32'h1000, 32'h40, 32'h100, 3);
        clear_logs();
        start();
        wait_line(1, "underrun_line1_timeout");
        start();
        chk("underrun_set", underrun, 1);
        wait_idle("underrun_timeout");
        chk("underrun_go_count", go_base_q.size(), 2);
        chk("underrun_no_frame_done", fdone_cnt, 0);
        underrun_clr = 1;
        cyc(1);
        chk("underrun_cleared", underrun, 0);
        start();
        cyc(2);
        frame_start = 1; underrun_clr = 1;
        cyc(1);
        chk("underrun_set_wins", underrun, 1);
        wait_idle("underrun2_timeout");
        underrun_clr = 1;
        cyc(1);

        // Stale done: held high, go every third cycle.
        lat = 0;
        commit(32'h0, 32'h10, 32'h10, 5);
        clear_logs();
        start();
        wait_idle("stale_timeout");
        chk("stale_go_count", go_cyc_q.size(), 5);
        for (int i = 1; i < go_cyc_q.size(); i++) chk("stale_gap", go_cyc_q[i] - go_cyc_q[i-1], 3);

        // Enable drop mid-line.
        lat = 20;
        commit(32'h4000, 32'h80, 32'h100, 4);
        clear_logs();
        start();
        wait_line(1, "endrop_line1_timeout");
        cfg_enable = 0;
        wait_idle("endrop_timeout");
        chk("endrop_go_count", go_base_q.size(), 2);
        chk("endrop_no_frame_done", fdone_cnt, 0);
        cfg_enable = 1;

        // Asynchronous reset mid-frame.
        commit(32'h5000, 32'h80, 32'h100, 4);
        start();
        wait_line(2, "rst_line2_timeout");
        cyc(3);
        start();
        chk("rst_pre_underrun", underrun, 1);
        #2;
        reset_n = 0;
        #1;
        chk("rst_rm_go", rm_go, 0);
        chk("rst_rm_base", rm_base, 0);
        chk("rst_rm_length", rm_length, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line_index", line_index, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_underrun", underrun, 0);
        cyc(3);
        reset_n = 1;
        cyc(1);
        commit(32'h6000, 32'h80, 32'h100, 2);
        start();
        chk("rst_restart_go", rm_go, 1);
        chk("rst_restart_index", line_index, 0);
        chk("rst_restart_base", rm_base, 32'h6000);
        wait_idle("rst_restart_timeout");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cfg_frame_base  = $urandom;
                cfg_line_bytes  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 255));
                cfg_line_stride = ($urandom_range(0, 3) == 0) ? $urandom : AW'($urandom_range(0, 4095));
                cfg_lines       = LW'($urandom_range(0, 4));
                cfg_commit      = 1;
            end
            if ($urandom_range(0, 29) == 0) frame_start = 1;
            if ($urandom_range(0, 59) == 0) cfg_enable = 0;
            else if (!cfg_enable && $urandom_range(0, 9) == 0) cfg_enable = 1;
            if ($urandom_range(0, 39) == 0) underrun_clr = 1;
            if ($urandom_range(0, 49) == 0) lat = $urandom_range(0, 6);
            cyc(1);
        end
        cfg_enable = 1;
        wait_idle("random_drain_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_frame_read_sequencer.md
# lcd_frame_read_sequencer

Per-frame controller for the burst read master in the LCD scanout path. It turns one frame description (base, line length, stride, line count) into a sequence of per-line go/base/length commands, waits for each line to drain before issuing the next, and applies double-buffered frame-base updates only at frame boundaries. It sits between the Avalon-MM control slave registers and the burst read master's control port, and reports frame completion and underrun to the LCD timing and interrupt logic.

## Interface
- ADDRESSWIDTH, 32, byte address and length width
- BYTEENABLEWIDTH, 4, bytes per master word; line length is truncated to a multiple of this
- LINESWIDTH, 12, width of line count and line index
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_enable  in  1  level; 1 = accept frame_start
- cfg_frame_base  in  ADDRESSWIDTH  next frame base (shadow input)
- cfg_line_bytes  in  ADDRESSWIDTH  bytes per line
- cfg_line_stride  in  ADDRESSWIDTH  byte offset between line starts
- cfg_lines  in  LINESWIDTH  lines per frame
- cfg_commit  in  1  pulse; copies cfg_* into the shadow set
- frame_start  in  1  pulse from LCD timing (vsync leading edge)
- underrun_clr  in  1  pulse; clears underrun
- rm_go  out  1  one-cycle go to the read master
- rm_base  out  ADDRESSWIDTH  line start address, held stable through the line
- rm_length  out  ADDRESSWIDTH  line byte length, held stable through the line
- rm_fixed_location  out  1  constant 0
- rm_done  in  1  read master done (length==0 and no reads pending)
- busy  out  1  frame in progress
- line_index  out  LINESWIDTH  index of the line currently issued
- frame_done  out  1  one-cycle pulse after the last line drains
- underrun  out  1  sticky; frame_start arrived while busy

## Operation
- Reset values: rm_go=0, rm_base=0, rm_length=0, busy=0, line_index=0, frame_done=0, underrun=0, shadow set=0, state IDLE.
- Shadow set: cfg_commit loads base, line_bytes & ~(BYTEENABLEWIDTH-1), stride, and lines. The active set loads from the shadow at frame_start acceptance only.
- States:
  - IDLE: accept on frame_start & cfg_enable. If the shadow lines==0 or line_bytes==0, pulse frame_done and stay in IDLE. Otherwise load the active set, set line_addr=base and line_index=0, and go to GO.
  - GO: rm_go=1, rm_base=line_addr, rm_length=active line_bytes; next state ARM.
  - ARM: rm_done is ignored, because the master's done is still high from the previous idle period; next state WAIT.
  - WAIT on rm_done=1:
    - If line_index==lines-1, or cfg_enable==0: go to IDLE. Pulse frame_done only if all lines were issued.
    - Otherwise set line_addr += stride (mod 2^ADDRESSWIDTH, wrap silent), line_index += 1, and go to GO.
- busy = (state != IDLE).
- frame_start while busy: set underrun. The master is never aborted; the current line finishes, the sequencer returns to IDLE, and the early frame_start is dropped. No frame restart.
- frame_start and underrun_clr in the same cycle while busy: underrun stays set (set wins).
- cfg_commit during a frame: affects only the next accepted frame.
- cfg_enable dropping mid-line: the current line completes, then IDLE with no frame_done.
- reset_n asserted mid-frame: immediate return to reset values. The read master is reset by its own reset, which is driven from the same source.

## Timing
- frame_start at cycle 0 (IDLE, accepted) → rm_go=1 at cycle 1, ARM at cycle 2, WAIT from cycle 3.
- rm_done sampled high in WAIT at cycle t → next rm_go at t+1.
- Minimum gap between successive rm_go pulses: 3 cycles.
- frame_done is asserted in the cycle after rm_done is sampled for the last line.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package lcd_seq_pkg:
  - state enum (IDLE, GO, ARM, WAIT)
  - localparam for the word alignment mask derived from BYTEENABLEWIDTH
- One sub-module, lcd_frame_cfg_shadow: the commit-loaded shadow register bank plus active-set copy-on-accept.
- FSM and address/index counters live in the top module.

## Test plan
- Basic frame: commit base=0x1000, line_bytes=0x640, stride=0x800, lines=3; pulse frame_start; bench master asserts done 20 cycles after each go → rm_base sequence 0x1000, 0x1800, 0x2000; rm_length=0x640 each; exactly one frame_done; busy falls after it.
- Alignment and empty frame: line_bytes=0x643 → rm_length=0x640. Then lines=0 → frame_done pulse 1 cycle after frame_start, with no rm_go.
- Double buffering: cfg_commit of base=0x9000 during line 1 of a frame based at 0x1000 → remaining lines stay 0x1xxx; next frame starts at 0x9000.
- Underrun: second frame_start during line 1 of 3 → underrun=1, current line completes, return to IDLE, no frame_done. Then underrun_clr → underrun=0. Simultaneous set and clear → underrun stays 1.
- Done-stale and gap: rm_done held high continuously → rm_go every 3 cycles. ARM never advances on the stale done of the previous line.
- Reset mid-frame: drop reset_n during WAIT of line 2 → all outputs return to reset values asynchronously; a new frame_start after release begins at line 0.
